intr_ctrl: RTL

- Memory-mapped interrupt source that drives the core's `timer_intr` and `ext_intr` inputs.
- Machine timer: 64-bit mtime/mtimecmp with a programmable prescaler.
- External-interrupt gateway: edge-latched pending bits, enable mask, and a single-level claim/complete handshake.
- Trap-handler software reaches it over a simple valid/ready register bus.

---
 rtl/intr_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// Interrupt source: 64-bit machine timer with prescaler plus an edge-latched external gateway with claim/complete.
// Latency: bus response one cycle after acceptance; timer_intr/ext_intr are registered one cycle after their condition.
// Backpressure: one request outstanding; req_ready is low while a response waits for resp_ready.
module intr_ctrl #(
    parameter int          NUM_SRC      = 8,
    parameter logic [31:0] PRESCALE_RST = 32'd1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               timer_intr,
    output logic               ext_intr
);

    localparam logic [2:0] A_MTIME_LO    = 3'd0;
    localparam logic [2:0] A_MTIME_HI    = 3'd1;
    localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] A_PRESCALE    = 3'd4;
    localparam logic [2:0] A_PENDING     = 3'd5;
    localparam logic [2:0] A_ENABLE      = 3'd6;
    localparam logic [2:0] A_CLAIM       = 3'd7;

    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic [31:0]        prescale_q, prescale_d;
    logic [31:0]        presc_cnt_q, presc_cnt_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
    logic [4:0]         in_service_q, in_service_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               timer_intr_q, timer_intr_d;
    logic               ext_intr_q, ext_intr_d;

    logic               acc, wr, rd, tick, claim;
    logic [NUM_SRC-1:0] rise, cand_oh, claim_mask;
    logic [4:0]         cand_id;
    logic [31:0]        rd_mux;

    // Ready is held low during reset so no request is taken while the block is cleared.
    assign req_ready  = rstn & ~resp_valid_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign timer_intr = timer_intr_q;
    assign ext_intr   = ext_intr_q;

    assign acc  = req_valid & req_ready;
    assign wr   = acc & req_we;
    assign rd   = acc & ~req_we;
    assign tick = (presc_cnt_q == prescale_q - 32'd1);
    assign rise = sync2_q & ~sync3_q;

    // Lowest-numbered enabled pending source; scanning downward lets the lowest hit win.
    always_comb begin
        cand_id = 5'd0;
        cand_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                cand_id    = 5'(i + 1);
                cand_oh    = '0;
                cand_oh[i] = 1'b1;
            end
        end
    end

    assign claim      = rd && (req_addr == A_CLAIM) && (in_service_q == 5'd0) && (cand_id != 5'd0);
    assign claim_mask = claim ? cand_oh : '0;

    // Read data reflects register state before the acceptance edge.
    always_comb begin
        rd_mux = 32'd0;
        case (req_addr)
            A_MTIME_LO:    rd_mux = mtime_q[31:0];
            A_MTIME_HI:    rd_mux = mtime_q[63:32];
            A_MTIMECMP_LO: rd_mux = mtimecmp_q[31:0];
            A_MTIMECMP_HI: rd_mux = mtimecmp_q[63:32];
            A_PRESCALE:    rd_mux = prescale_q;
            A_PENDING:     rd_mux = 32'(pending_q);
            A_ENABLE:      rd_mux = 32'(enable_q);
            A_CLAIM:       rd_mux = (in_service_q == 5'd0) ? 32'(cand_id) : 32'd0;
            default:       rd_mux = 32'd0;
        endcase
    end

    // Timer datapath: a bus write to an mtime half overrides a tick in the same cycle.
    always_comb begin
        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        prescale_d  = prescale_q;
        presc_cnt_d = tick ? 32'd0 : presc_cnt_q + 32'd1;
        if (wr) begin
            case (req_addr)
                A_MTIME_LO:    mtime_d    = {mtime_q[63:32], req_wdata};
                A_MTIME_HI:    mtime_d    = {req_wdata, mtime_q[31:0]};
                A_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], req_wdata};
                A_MTIMECMP_HI: mtimecmp_d = {req_wdata, mtimecmp_q[31:0]};
                A_PRESCALE: begin
                    prescale_d  = (req_wdata == 32'd0) ? 32'd1 : req_wdata;
                    presc_cnt_d = 32'd0;
                end
                default: ;
            endcase
        end
    end

    // Gateway: new edges take priority over the claim clear of the same bit.
    always_comb begin
        pending_d    = (pending_q & ~claim_mask) | rise;
        enable_d     = enable_q;
        in_service_d = in_service_q;
        if (wr && req_addr == A_ENABLE) begin
            enable_d = req_wdata[NUM_SRC-1:0];
        end
        if (claim) begin
            in_service_d = cand_id;
        end else if (wr && req_addr == A_CLAIM && req_wdata[4:0] == in_service_q) begin
            in_service_d = 5'd0;
        end
    end

    // Response holding register and registered interrupt outputs.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        if (acc) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_we ? 32'd0 : rd_mux;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
            resp_rdata_d = 32'd0;
        end
        timer_intr_d = (mtime_q >= mtimecmp_q);
        ext_intr_d   = (|(pending_q & enable_q)) && (in_service_q == 5'd0);
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_q   <= PRESCALE_RST;
            presc_cnt_q  <= 32'd0;
            pending_q    <= '0;
            enable_q     <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            in_service_q <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            timer_intr_q <= 1'b0;
            ext_intr_q   <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            prescale_q   <= prescale_d;
            presc_cnt_q  <= presc_cnt_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            sync1_q      <= src_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            in_service_q <= in_service_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            timer_intr_q <= timer_intr_d;
            ext_intr_q   <= ext_intr_d;
        end
    end

endmodule
